// File: rtl/shifter_arbiter_if.sv
// Request/result handshake bundle for shifter_arbiter: two requesters in, one result out.
// Every transfer completes on a cycle where valid & ready are both high.
interface shifter_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_in;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_op;
    logic [31:0] req1_in;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_op;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_err;

    modport master (
        output req_valid, req0_in, req0_shamt, req0_op,
        output req1_in, req1_shamt, req1_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err
    );

    modport slave (
        input  req_valid, req0_in, req0_shamt, req0_op,
        input  req1_in, req1_shamt, req1_op, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err
    );
endinterface

// File: rtl/shifter_arbiter.sv
// Two requesters share one SLL/SRL/SRA shifter set under round-robin arbitration; result
// is registered in a single-entry buffer. `SHIFTER_ARB_ROTATE_EN enables op 11 = rotate left.
module shifter_arbiter (
    input  logic              clk,
    input  logic              rst,
    shifter_arbiter_if.slave  bus,
    output logic              dbg_state,
    output logic              dbg_rr_ptr
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_id_q, res_id_d;
    logic        res_err_q, res_err_d;

    logic        can_accept;
    logic        gnt_idx;
    logic [1:0]  gnt_vec;
    logic        accept;
    logic [31:0] sel_in;
    logic [4:0]  sel_shamt;
    logic [1:0]  sel_op;
    logic [5:0]  srl_amt;
    logic [31:0] sll_out, srl_out, sra_out;
    logic [31:0] shift_res;
    logic        shift_err;

    // Arbitration and shared datapath
    always_comb begin
        can_accept = (state_q == EMPTY) | bus.res_ready;
        if (bus.req_valid == 2'b11) begin
            gnt_idx = rr_ptr_q;
        end else begin
            gnt_idx = bus.req_valid[1];
        end
        gnt_vec = 2'b00;
        if (rst && can_accept && (bus.req_valid != 2'b00)) begin
            gnt_vec = gnt_idx ? 2'b10 : 2'b01;
        end
        accept = |(bus.req_valid & gnt_vec);

        sel_in    = gnt_idx ? bus.req1_in    : bus.req0_in;
        sel_shamt = gnt_idx ? bus.req1_shamt : bus.req0_shamt;
        sel_op    = gnt_idx ? bus.req1_op    : bus.req0_op;

`ifdef SHIFTER_ARB_ROTATE_EN
        // Rotate reuses the SRL instance with the complementary amount; 32 shifts out to 0.
        srl_amt = (sel_op == 2'b11) ? (6'd32 - {1'b0, sel_shamt}) : {1'b0, sel_shamt};
`else
        srl_amt = {1'b0, sel_shamt};
`endif
        sll_out = sel_in << sel_shamt;
        srl_out = sel_in >> srl_amt;
        sra_out = 32'($signed(sel_in) >>> sel_shamt);

        shift_err = 1'b0;
        case (sel_op)
            2'b00:   shift_res = sll_out;
            2'b01:   shift_res = srl_out;
            2'b10:   shift_res = sra_out;
            default: begin
`ifdef SHIFTER_ARB_ROTATE_EN
                shift_res = sll_out | srl_out;
`else
                shift_res = 32'd0;
                shift_err = 1'b1;
`endif
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= 1'b0;
            res_data_q <= 32'd0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    // Next state: an accept always refills the buffer, so FULL only empties without one
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_err_d  = res_err_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (bus.res_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            rr_ptr_d   = ~gnt_idx;
            res_data_d = shift_res;
            res_id_d   = gnt_idx;
            res_err_d  = shift_err;
        end
    end

    // Outputs
    always_comb begin
        bus.req_ready = gnt_vec;
        bus.res_valid = (state_q == FULL);
        bus.res_data  = res_data_q;
        bus.res_id    = res_id_q;
        bus.res_err   = res_err_q;
        dbg_state     = (state_q == FULL);
        dbg_rr_ptr    = rr_ptr_q;
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: arithmetic reference model with a one-deep expected
// queue checked every cycle, plus literal expectations for each scenario.
module tb_shifter_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic dbg_state, dbg_rr_ptr;
  int tests_run = 0;
  int tests_failed = 0;

  shifter_arbiter_if bus();

  shifter_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: {id, err, data}
  function automatic logic [33:0] model_shift(input logic [31:0] x, input logic [4:0] s,
                                              input logic [1:0] op, input logic id);
    longint unsigned pw, xv, r, two32;
    logic err;
    two32 = 64'h1_0000_0000;
    pw = 1;
    for (int i = 0; i < int'(s); i++) pw = pw * 2;
    xv = {32'd0, x};
    err = 1'b0;
    case (op)
      2'b00: r = (xv * pw) % two32;
      2'b01: r = xv / pw;
      2'b10: r = x[31] ? (64'hFFFF_FFFF - ((64'hFFFF_FFFF - xv) / pw)) : (xv / pw);
      default: begin
`ifdef SHIFTER_ARB_ROTATE_EN
        r = ((xv * pw) % two32) + (xv / (two32 / pw));
`else
        r = 0;
        err = 1'b1;
`endif
      end
    endcase
    return {id, err, r[31:0]};
  endfunction

  // scoreboard
  logic [33:0] exp_q[$];
  logic        m_ptr = 1'b0;
  logic        m_full, m_can, m_g;
  logic [1:0]  m_v, m_rdy;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_ptr = 1'b0;
      check("rst_req_ready", bus.req_ready, 2'b00);
      check("rst_res_valid", bus.res_valid, 1'b0);
    end else begin
      m_full = (exp_q.size() != 0);
      m_can  = !m_full || bus.res_ready;
      m_v    = bus.req_valid;
      m_g    = (m_v == 2'b11) ? m_ptr : m_v[1];
      m_rdy  = (m_can && m_v != 2'b00) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      check("model_req_ready", bus.req_ready, m_rdy);
      check("model_res_valid", bus.res_valid, m_full);
      if (m_full) check("model_result", {bus.res_id, bus.res_err, bus.res_data}, exp_q[0]);
      if (m_full && bus.res_ready) void'(exp_q.pop_front());
      if (m_rdy != 2'b00) begin
        if (m_g) exp_q.push_back(model_shift(bus.req1_in, bus.req1_shamt, bus.req1_op, 1'b1));
        else     exp_q.push_back(model_shift(bus.req0_in, bus.req0_shamt, bus.req0_op, 1'b0));
        m_ptr = ~m_g;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic [31:0] x, input logic [4:0] s, input logic [1:0] op);
    if (r) begin
      bus.req1_in = x; bus.req1_shamt = s; bus.req1_op = op;
    end else begin
      bus.req0_in = x; bus.req0_shamt = s; bus.req0_op = op;
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b00;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic single_req(input string name, input logic r, input logic [31:0] x, input logic [4:0] s,
                            input logic [1:0] op, input logic [31:0] exp_d, input logic exp_e);
    logic got;
    bus.res_ready = 1'b1;
    set_req(r, x, s, op);
    bus.req_valid = r ? 2'b10 : 2'b01;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (bus.req_ready == bus.req_valid);
      tick();
    end
    check({name, "_accept"}, got, 1'b1);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check({name, "_valid"}, bus.res_valid, 1'b1);
    check({name, "_data"}, bus.res_data, exp_d);
    check({name, "_err"}, bus.res_err, exp_e);
    check({name, "_id"}, bus.res_id, r);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    set_req(1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1'b1, 32'h0, 5'd0, 2'b00);

    // reset with both requesters valid
    repeat (3) begin
      @(negedge clk);
      check("t1_req_ready", bus.req_ready, 2'b00);
      check("t1_res_valid", bus.res_valid, 1'b0);
      check("t1_res_data", bus.res_data, 32'h0);
      check("t1_rr_ptr", dbg_rr_ptr, 1'b0);
    end
    tick();
    rst = 1'b1;
    bus.req_valid = 2'b00;

    // single request, one-cycle latency
    bus.res_ready = 1'b1;
    set_req(1'b0, 32'h0000_00F1, 5'd4, 2'b00);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t2_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t2_res_valid", bus.res_valid, 1'b1);
    check("t2_res_data", bus.res_data, 32'h0000_0F10);
    check("t2_res_id", bus.res_id, 1'b0);
    tick();

    // contention alternates grants from rr_ptr=0
    do_reset();
    set_req(1'b0, 32'h8000_0000, 5'd31, 2'b01);
    set_req(1'b1, 32'h8000_0000, 5'd31, 2'b10);
    bus.res_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("t3_data", bus.res_data, (k % 2 == 1) ? 32'h0000_0001 : 32'hFFFF_FFFF);
        check("t3_id", bus.res_id, (k % 2 == 1) ? 1'b0 : 1'b1);
      end
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // backpressure with pass-through refill
    set_req(1'b0, 32'h0000_0001, 5'd3, 2'b00);
    set_req(1'b1, 32'h0000_00F0, 5'd4, 2'b01);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t4_grant0", bus.req_ready, 2'b01);
    tick();
    @(negedge clk);
    check("t4_grant1", bus.req_ready, 2'b10);
    check("t4_first", bus.res_data, 32'h0000_0008);
    tick();
    bus.res_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_ready", bus.req_ready, 2'b00);
      check("t4_stall_valid", bus.res_valid, 1'b1);
      check("t4_stall_data", bus.res_data, 32'h0000_000F);
      check("t4_stall_id", bus.res_id, 1'b1);
      tick();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t4_refill_ready", bus.req_ready, 2'b01);
    check("t4_refill_held", bus.res_data, 32'h0000_000F);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t4_refill_data", bus.res_data, 32'h0000_0008);
    check("t4_refill_id", bus.res_id, 1'b0);
    tick();

    // op 11 and boundary shift amounts
`ifdef SHIFTER_ARB_ROTATE_EN
    single_req("t5_rot", 1'b1, 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0003, 1'b0);
    single_req("t5_rot0", 1'b0, 32'h1234_5678, 5'd0, 2'b11, 32'h1234_5678, 1'b0);
`else
    single_req("t5_err", 1'b1, 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0000, 1'b1);
    single_req("t5_err0", 1'b0, 32'h1234_5678, 5'd0, 2'b11, 32'h0000_0000, 1'b1);
`endif
    single_req("sll31", 1'b0, 32'h8000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
    single_req("sll0", 1'b1, 32'hA5A5_A5A5, 5'd0, 2'b00, 32'hA5A5_A5A5, 1'b0);
    single_req("sra0", 1'b0, 32'h8000_0000, 5'd0, 2'b10, 32'h8000_0000, 1'b0);
    single_req("sra31_pos", 1'b1, 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0);
    single_req("srl31", 1'b0, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001, 1'b0);
    single_req("sra4", 1'b1, 32'hF000_0000, 5'd4, 2'b10, 32'hFF00_0000, 1'b0);

    // reset while a result is held
    bus.res_ready = 1'b0;
    set_req(1'b0, 32'h0000_0011, 5'd1, 2'b00);
    set_req(1'b1, 32'h0000_0022, 5'd1, 2'b01);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t6_held_valid", bus.res_valid, 1'b1);
    check("t6_ptr_before", dbg_rr_ptr, 1'b1);
    tick();
    #1;
    rst = 1'b0;
    #1;
    check("t6_drop_valid", bus.res_valid, 1'b0);
    check("t6_ptr_reset", dbg_rr_ptr, 1'b0);
    check("t6_ready_low", bus.req_ready, 2'b00);
    repeat (2) tick();
    rst = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("t6_first_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t6_first_data", bus.res_data, 32'h0000_0022);
    check("t6_first_id", bus.res_id, 1'b0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
